// File: rtl/operand_fetch.sv
// Operand-fetch/issue stage with a destination scoreboard in front of the 64x64 register file.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data into the operand muxes.
module operand_fetch #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 6,
   parameter int REG_N  = 64,
   parameter int OP_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inValid,
   output logic              inReady,
   input  logic [OP_W-1:0]   inOp,
   input  logic [ADDR_W-1:0] inRs1,
   input  logic [ADDR_W-1:0] inRs2,
   input  logic [ADDR_W-1:0] inRd,
   input  logic              inRdWrite,
   output logic [ADDR_W-1:0] readAdr1,
   output logic [ADDR_W-1:0] readAdr2,
   input  logic [DATA_W-1:0] readData1,
   input  logic [DATA_W-1:0] readData2,
   input  logic              wbEnable,
   input  logic [ADDR_W-1:0] wbAdr,
   input  logic [DATA_W-1:0] wbData,
   output logic              outValid,
   input  logic              outReady,
   output logic [OP_W-1:0]   outOp,
   output logic [ADDR_W-1:0] outRd,
   output logic              outRdWrite,
   output logic [DATA_W-1:0] outOperand1,
   output logic [DATA_W-1:0] outOperand2,
   output logic [31:0]       stallCycles
);

   logic [REG_N-1:0]  busy_q, busy_d;
   logic              outValid_q, outValid_d;
   logic [OP_W-1:0]   outOp_q;
   logic [ADDR_W-1:0] outRd_q;
   logic              outRdWrite_q;
   logic [DATA_W-1:0] outOperand1_q, outOperand2_q;
   logic [31:0]       stall_q, stall_d;

   logic              byp1, byp2;
   logic [DATA_W-1:0] operand1, operand2;
   logic              raw1, raw2, waw, hazard, accept;

   assign readAdr1 = inRs1;
   assign readAdr2 = inRs2;

`ifdef OPERAND_FETCH_BYPASS_EN
   assign byp1     = wbEnable && (wbAdr == inRs1);
   assign byp2     = wbEnable && (wbAdr == inRs2);
   assign operand1 = byp1 ? wbData : readData1;
   assign operand2 = byp2 ? wbData : readData2;
`else
   // Without forwarding, wbData only reaches the register file, never this stage.
   logic unusedWbData;
   assign unusedWbData = ^wbData;
   assign byp1     = 1'b0;
   assign byp2     = 1'b0;
   assign operand1 = readData1;
   assign operand2 = readData2;
`endif

   assign raw1    = busy_q[inRs1] && !byp1;
   assign raw2    = busy_q[inRs2] && !byp2;
   assign waw     = inRdWrite && busy_q[inRd];
   assign hazard  = raw1 || raw2 || waw;
   assign inReady = (!outValid_q || outReady) && !hazard;
   assign accept  = inValid && inReady;

   // Set is applied after clear so an issuing writer keeps its register busy.
   always_comb begin
      busy_d = busy_q;
      if (wbEnable) begin
         busy_d[wbAdr] = 1'b0;
      end
      if (accept && inRdWrite) begin
         busy_d[inRd] = 1'b1;
      end
   end

   always_comb begin
      outValid_d = outValid_q;
      if (accept) begin
         outValid_d = 1'b1;
      end else if (outValid_q && outReady) begin
         outValid_d = 1'b0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (inValid && hazard && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         outValid_q <= 1'b0;
         stall_q    <= '0;
      end else begin
         busy_q     <= busy_d;
         outValid_q <= outValid_d;
         stall_q    <= stall_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outOp_q       <= '0;
         outRd_q       <= '0;
         outRdWrite_q  <= 1'b0;
         outOperand1_q <= '0;
         outOperand2_q <= '0;
      end else if (accept) begin
         outOp_q       <= inOp;
         outRd_q       <= inRd;
         outRdWrite_q  <= inRdWrite;
         outOperand1_q <= operand1;
         outOperand2_q <= operand2;
      end
   end

   assign outValid    = outValid_q;
   assign outOp       = outOp_q;
   assign outRd       = outRd_q;
   assign outRdWrite  = outRdWrite_q;
   assign outOperand1 = outOperand1_q;
   assign outOperand2 = outOperand2_q;
   assign stallCycles = stall_q;

endmodule
